// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencer.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_HALT     = 2'd2
   } state_e;

   localparam int REG_AW_DEF      = 2;
   localparam int MEM_TIMEOUT_DEF = 15;
   localparam int CNT_W_DEF       = 16;

   // A flushed pipeline register holds this instruction word.
   localparam logic [9:0] NOP_INSTR = 10'b0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use compare between the load in EX and the source registers in ID.
module hazard_detect
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_uses_rs2,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_is_load,
   output logic              load_use
);

   // r0 never creates a dependency since it always reads zero.
   assign load_use = ex_is_load && (ex_rd != '0) &&
                     ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Central sequencer: pipeline register enables/flushes, RAM handshake, halt/resume.
//   state       | meaning
//   ST_RUN      | normal issue; load-use bubbles and branch squashes
//   ST_MEM_WAIT | RAM access outstanding, whole pipeline held
//   ST_HALT     | pipeline frozen until resume
module pipeline_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW      = REG_AW_DEF,
   parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_uses_rs2,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_is_load,
   input  logic              ex_mem_access,
   input  logic              ram_ack,
   input  logic              branch_taken,
   input  logic              halt_in,
   input  logic              resume,
   output logic              pc_en,
   output logic              ifid_en,
   output logic              idex_en,
   output logic              exmemwb_en,
   output logic              ifid_flush,
   output logic              idex_flush,
   output logic              ram_req,
   output logic [1:0]        state,
   output logic              mem_err,
   output logic [CNT_W-1:0]  stall_count
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   state_e              state_q, state_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic                mem_err_q, mem_err_d;
   logic [CNT_W-1:0]    stall_count_q, stall_count_d;
   logic                load_use;
   logic                wait_last;

   hazard_detect #(.REG_AW(REG_AW)) u_hazard (
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_uses_rs2 (id_uses_rs2),
      .ex_rd       (ex_rd),
      .ex_is_load  (ex_is_load),
      .load_use    (load_use)
   );

   assign wait_last = (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1));

   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      mem_err_d     = mem_err_q;
      stall_count_d = stall_count_q;
      pc_en         = 1'b0;
      ifid_en       = 1'b0;
      idex_en       = 1'b0;
      exmemwb_en    = 1'b0;
      ifid_flush    = 1'b0;
      idex_flush    = 1'b0;
      ram_req       = 1'b0;

      // Controls are forced quiet for as long as reset is held.
      if (reset) begin
         case (state_q)
            ST_RUN: begin
               pc_en      = 1'b1;
               ifid_en    = 1'b1;
               idex_en    = 1'b1;
               exmemwb_en = 1'b1;
               ram_req    = ex_mem_access;
               if (ex_mem_access && !ram_ack) begin
                  pc_en      = 1'b0;
                  ifid_en    = 1'b0;
                  idex_en    = 1'b0;
                  exmemwb_en = 1'b0;
                  wait_cnt_d = '0;
                  state_d    = ST_MEM_WAIT;
               end else begin
                  if (branch_taken) begin
                     ifid_flush = 1'b1;
                     idex_flush = 1'b1;
                  end else if (load_use) begin
                     pc_en      = 1'b0;
                     ifid_en    = 1'b0;
                     idex_flush = 1'b1;
                  end
                  if (halt_in && !ex_mem_access) state_d = ST_HALT;
               end
            end
            ST_MEM_WAIT: begin
               ram_req = 1'b1;
               if (ram_ack) begin
                  pc_en      = 1'b1;
                  ifid_en    = 1'b1;
                  idex_en    = 1'b1;
                  exmemwb_en = 1'b1;
                  ifid_flush = branch_taken;
                  idex_flush = branch_taken;
                  state_d    = ST_RUN;
               end else if (wait_last) begin
                  mem_err_d  = 1'b1;
                  wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                  state_d    = ST_HALT;
               end else begin
                  wait_cnt_d = wait_cnt_q + WAIT_W'(1);
               end
            end
            ST_HALT: begin
               if (resume) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
         endcase
      end

      if (!pc_en && (state_q != ST_HALT) && (stall_count_q != {CNT_W{1'b1}}))
         stall_count_d = stall_count_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_RUN;
         wait_cnt_q    <= '0;
         mem_err_q     <= 1'b0;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_err_q     <= mem_err_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign state       = state_q;
   assign mem_err     = mem_err_q;
   assign stall_count = stall_count_q;

endmodule
